// File: rtl/fitness_pkg.sv
// ---------------------------------------------------------------------------
// Module      : fitness_pkg
// Description : Beep command encodings, sequencer states, default ms timing.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fitness_pkg;

  typedef enum logic [1:0] {
    BEEP_SHORT  = 2'd0,
    BEEP_DOUBLE = 2'd1,
    BEEP_LONG   = 2'd2,
    BEEP_TRIPLE = 2'd3
  } beep_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_TONE = 2'd1,
    SEQ_GAP  = 2'd2
  } seq_state_t;

  localparam int c_SHORT_MS = 100;
  localparam int c_GAP_MS   = 100;
  localparam int c_LONG_MS  = 500;
  localparam int c_CNT_W    = 10;

  function automatic logic [1:0] beep_count(input logic [1:0] i_type);
    case (i_type)
      2'd1:    return 2'd2;
      2'd3:    return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ---------------------------------------------------------------------------
// Module      : rise_detect
// Description : One-bit history register with a rising-edge pulse output.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= i_d;
    end
  end

  assign o_rise = i_d & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/buzzer_sequencer.sv
// ---------------------------------------------------------------------------
// Module      : buzzer_sequencer
// Description : Turns one-shot beep commands into gated tone patterns.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module buzzer_sequencer
  import fitness_pkg::*;
#(
  parameter int SHORT_MS = c_SHORT_MS,
  parameter int GAP_MS   = c_GAP_MS,
  parameter int LONG_MS  = c_LONG_MS,
  parameter int CNT_W    = c_CNT_W
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clk_500Hz,
  input  logic       clk_1kHz,
  input  logic       clk_2kHz,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] c_SHORT_LAST = CNT_W'(SHORT_MS - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST  = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_MS - 1);

  seq_state_t       r_state;
  beep_t            r_type;
  logic [CNT_W-1:0] r_ms_cnt;
  logic [1:0]       r_beeps_left;
  logic             r_buzzer;
  logic             r_done;

  logic             w_ms_tick;
  logic             w_tone;
  logic [CNT_W-1:0] w_tone_last;

  rise_detect u_ms_tick (
    .clk    (clk_in),
    .rst_n  (reset),
    .i_d    (clk_1kHz),
    .o_rise (w_ms_tick)
  );

  always_comb begin
    w_tone      = clk_1kHz;
    w_tone_last = c_SHORT_LAST;
    case (r_type)
      BEEP_SHORT: w_tone = clk_2kHz;
      BEEP_LONG: begin
        w_tone      = clk_500Hz;
        w_tone_last = c_LONG_LAST;
      end
      default: w_tone = clk_1kHz;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state      <= SEQ_IDLE;
      r_type       <= BEEP_SHORT;
      r_ms_cnt     <= '0;
      r_beeps_left <= 2'd0;
      r_buzzer     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_buzzer <= (r_state == SEQ_TONE) & w_tone;
      if (abort) begin
        // Abort wins over every transition, including a same-cycle command.
        r_state      <= SEQ_IDLE;
        r_buzzer     <= 1'b0;
        r_ms_cnt     <= '0;
        r_beeps_left <= 2'd0;
      end else begin
        case (r_state)
          SEQ_IDLE: begin
            if (cmd_valid) begin
              r_state      <= SEQ_TONE;
              r_type       <= beep_t'(cmd_type);
              r_ms_cnt     <= '0;
              r_beeps_left <= beep_count(cmd_type);
            end
          end
          SEQ_TONE: begin
            if (w_ms_tick) begin
              if (r_ms_cnt == w_tone_last) begin
                r_ms_cnt     <= '0;
                r_beeps_left <= r_beeps_left - 2'd1;
                if (r_beeps_left == 2'd1) begin
                  r_state <= SEQ_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= SEQ_GAP;
                end
              end else begin
                r_ms_cnt <= r_ms_cnt + CNT_W'(1);
              end
            end
          end
          SEQ_GAP: begin
            if (w_ms_tick) begin
              if (r_ms_cnt == c_GAP_LAST) begin
                r_ms_cnt <= '0;
                r_state  <= SEQ_TONE;
              end else begin
                r_ms_cnt <= r_ms_cnt + CNT_W'(1);
              end
            end
          end
          default: r_state <= SEQ_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (r_state == SEQ_IDLE);
  assign busy      = (r_state != SEQ_IDLE);
  assign buzzer    = r_buzzer;
  assign done      = r_done;

endmodule

`default_nettype wire
